// File: rtl/mtm_alu_pkg.sv
// Shared types, frame constants and the CRC4 helper for the mtm_Alu input path.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    AND_OP = 3'b000,
    OR_OP  = 3'b001,
    ADD_OP = 3'b100,
    SUB_OP = 3'b101
  } operation_t;

  typedef enum logic {
    DATA = 1'b0,
    CMD  = 1'b1
  } packet_t;

  typedef enum logic [2:0] {
    ERR_NONE = 3'b000,
    ERR_DATA = 3'b100,
    ERR_CRC  = 3'b010,
    ERR_OP   = 3'b001
  } processing_error_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 11;

  // Serial CRC4, polynomial x^4+x+1, d[67] is the first bit shifted in.
  function automatic logic [3:0] crc4_d68(input logic [67:0] d, input logic [3:0] init);
    logic [3:0] c;
    logic       fb;
    c = init;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ ({4{fb}} & 4'b0011);
    end
    return c;
  endfunction

endpackage

// File: rtl/mtm_alu_rx_frame.sv
// Frame receiver: start detect, 10-bit body count, type bit and 8-bit data shift register.
module mtm_alu_rx_frame
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic       frame_done,
  output packet_t    frame_type,
  output logic [7:0] frame_byte,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, RX_BITS, CHECK} rx_state_t;

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  rx_state_t  state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  packet_t    type_q, type_d;
  logic [7:0] shift_q, shift_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      type_q    <= DATA;
      shift_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      type_q    <= type_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    type_d     = type_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (sin == START_BIT) begin
          state_d   = RX_BITS;
          bit_cnt_d = 4'd1;
        end
      end
      RX_BITS: begin
        if (bit_cnt_q == 4'd1) begin
          type_d = packet_t'(sin);
        end else if (bit_cnt_q < LAST_BIT) begin
          shift_d = {shift_q[6:0], sin};
        end
        // The stop bit is judged live so the top can register the result this edge.
        if (bit_cnt_q == LAST_BIT) begin
          frame_done = 1'b1;
          state_d    = CHECK;
          bit_cnt_d  = 4'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      CHECK: begin
        // Accepting a start here keeps back-to-back 11-bit frames aligned.
        if (sin == START_BIT) begin
          state_d   = RX_BITS;
          bit_cnt_d = 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_type = type_q;
  assign frame_byte = shift_q;
  assign frame_err  = (sin != STOP_BIT);

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_Alu input stage: collects 8 DATA bytes into {B,A}, validates each CMD frame and
// emits one decoded instruction or one error code per CMD.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int         N_DATA_FRAMES = 8,
  parameter logic [3:0] CRC_INIT      = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        instr_valid,
  output logic [31:0] A_out,
  output logic [31:0] B_out,
  output logic [2:0]  op_out,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  localparam logic [3:0] CNT_FULL = 4'(N_DATA_FRAMES);
  localparam logic [3:0] CNT_SAT  = 4'(N_DATA_FRAMES + 1);

  logic       frame_done;
  packet_t    frame_type;
  logic [7:0] frame_byte;
  logic       frame_err;

  mtm_alu_rx_frame u_rx_frame (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .frame_done (frame_done),
    .frame_type (frame_type),
    .frame_byte (frame_byte),
    .frame_err  (frame_err)
  );

  logic [3:0]        data_cnt_q, data_cnt_d;
  logic [63:0]       buf_q, buf_d;
  logic              instr_valid_q, instr_valid_d;
  logic              err_valid_q, err_valid_d;
  processing_error_t err_flags_q, err_flags_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;

  logic [2:0] cmd_op;
  logic [3:0] cmd_crc;
  logic       op_legal;
  logic       unused_cmd_msb;

  assign cmd_op         = frame_byte[6:4];
  assign cmd_crc        = frame_byte[3:0];
  assign unused_cmd_msb = frame_byte[7];
  assign op_legal       = (cmd_op == AND_OP) || (cmd_op == OR_OP) ||
                          (cmd_op == ADD_OP) || (cmd_op == SUB_OP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_cnt_q    <= 4'd0;
      buf_q         <= 64'd0;
      instr_valid_q <= 1'b0;
      err_valid_q   <= 1'b0;
      err_flags_q   <= ERR_NONE;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      op_q          <= 3'd0;
    end else begin
      data_cnt_q    <= data_cnt_d;
      buf_q         <= buf_d;
      instr_valid_q <= instr_valid_d;
      err_valid_q   <= err_valid_d;
      err_flags_q   <= err_flags_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
    end
  end

  always_comb begin
    data_cnt_d    = data_cnt_q;
    buf_d         = buf_q;
    instr_valid_d = 1'b0;
    err_valid_d   = 1'b0;
    err_flags_d   = ERR_NONE;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    if (frame_done) begin
      if (frame_err) begin
        err_valid_d = 1'b1;
        err_flags_d = ERR_DATA;
        data_cnt_d  = 4'd0;
        buf_d       = 64'd0;
      end else if (frame_type == DATA) begin
        buf_d = {buf_q[55:0], frame_byte};
        if (data_cnt_q != CNT_SAT) data_cnt_d = data_cnt_q + 4'd1;
      end else begin
        // Every CMD closes the instruction, whether or not it is accepted.
        data_cnt_d = 4'd0;
        buf_d      = 64'd0;
        if (data_cnt_q != CNT_FULL) begin
          err_valid_d = 1'b1;
          err_flags_d = ERR_DATA;
        end else if (cmd_crc != crc4_d68({buf_q, 1'b1, cmd_op}, CRC_INIT)) begin
          err_valid_d = 1'b1;
          err_flags_d = ERR_CRC;
        end else if (!op_legal) begin
          err_valid_d = 1'b1;
          err_flags_d = ERR_OP;
        end else begin
          instr_valid_d = 1'b1;
          b_d           = buf_q[63:32];
          a_d           = buf_q[31:0];
          op_d          = cmd_op;
        end
      end
    end
  end

  assign instr_valid = instr_valid_q;
  assign err_valid   = err_valid_q;
  assign err_flags   = err_flags_q;
  assign A_out       = a_q;
  assign B_out       = b_q;
  assign op_out      = op_q;

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Self-checking bench for mtm_alu_deserializer: directed cases plus randomized
// instruction streams compared against a frame-level reference model.
module tb_mtm_alu_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        instr_valid;
  logic [31:0] A_out;
  logic [31:0] B_out;
  logic [2:0]  op_out;
  logic        err_valid;
  logic [2:0]  err_flags;

  mtm_alu_deserializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .instr_valid (instr_valid),
    .A_out       (A_out),
    .B_out       (B_out),
    .op_out      (op_out),
    .err_valid   (err_valid),
    .err_flags   (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: bytes received since the last CMD, and held outputs.
  logic [7:0]  data_q[$];
  logic [31:0] mdl_a, mdl_b;
  logic [2:0]  mdl_op;
  int          exp_iv_cycles = 0;
  int          exp_ev_cycles = 0;
  int          iv_cycles = 0;
  int          ev_cycles = 0;
  int          both_cycles = 0;

  always @(posedge clk) begin
    if (instr_valid) iv_cycles <= iv_cycles + 1;
    if (err_valid) ev_cycles <= ev_cycles + 1;
    if (instr_valid && err_valid) both_cycles <= both_cycles + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of polynomial long division of D(x)*x^4 by x^4+x+1 (seed 0).
  function automatic logic [3:0] model_crc(input logic [67:0] d);
    logic [71:0] r;
    r = {d, 4'h0};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  // Sends one 11-bit frame; returns during the cycle after the stop bit and checks outputs.
  task automatic send_frame(input logic typ, input logic [7:0] b, input logic stop);
    logic [10:0] bits;
    logic        exp_iv;
    logic [2:0]  exp_err;
    logic [31:0] fa, fb;
    bits = {1'b0, typ, b, stop};
    for (int i = 10; i >= 0; i--) begin
      sin = bits[i];
      @(posedge clk);
      #1;
    end
    sin = 1'b1;
    exp_iv  = 1'b0;
    exp_err = 3'b000;
    if (stop == 1'b0) begin
      exp_err = 3'b100;
      data_q.delete();
    end else if (typ == 1'b0) begin
      data_q.push_back(b);
    end else begin
      if (data_q.size() != 8) begin
        exp_err = 3'b100;
      end else begin
        fb = {data_q[0], data_q[1], data_q[2], data_q[3]};
        fa = {data_q[4], data_q[5], data_q[6], data_q[7]};
        if (b[3:0] != model_crc({fb, fa, 1'b1, b[6:4]})) exp_err = 3'b010;
        else if (!(b[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) exp_err = 3'b001;
        else begin
          exp_iv = 1'b1;
          mdl_a  = fa;
          mdl_b  = fb;
          mdl_op = b[6:4];
        end
      end
      data_q.delete();
    end
    if (exp_iv) exp_iv_cycles++;
    if (exp_err != 3'b000) exp_ev_cycles++;
    if (typ == 1'b1 || stop == 1'b0) begin
      check_val("instr_valid", 64'(instr_valid), 64'(exp_iv));
      check_val("err_valid", 64'(err_valid), 64'(exp_err != 3'b000));
      check_val("err_flags", 64'(err_flags), 64'(exp_err));
      check_val("A_out", 64'(A_out), 64'(mdl_a));
      check_val("B_out", 64'(B_out), 64'(mdl_b));
      check_val("op_out", 64'(op_out), 64'(mdl_op));
    end else begin
      check_val("no_pulse_data", 64'({instr_valid, err_valid, err_flags}), 64'd0);
    end
  endtask

  // ndata DATA frames (taken from B then A when ndata==8) followed by a CMD frame.
  task automatic send_instr(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [3:0] crc_xor, input int ndata);
    logic [63:0] ba;
    logic [3:0]  crc;
    ba = {b, a};
    for (int i = 0; i < ndata; i++) begin
      if (ndata == 8) send_frame(1'b0, ba[63 - 8*i -: 8], 1'b1);
      else send_frame(1'b0, 8'($urandom), 1'b1);
    end
    crc = model_crc({b, a, 1'b1, op}) ^ crc_xor;
    send_frame(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] rop;
    rst_n  = 1'b0;
    sin    = 1'b1;
    mdl_a  = 32'd0;
    mdl_b  = 32'd0;
    mdl_op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {instr_valid, err_valid, err_flags, op_out, A_out[15:0], B_out[15:0]}, 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic ADD, then SUB with inverted CRC.
    send_instr(32'h0000_0003, 32'h0000_0005, 3'b100, 4'h0, 8);
    idle(1);
    check_val("pulse_width", 64'({instr_valid, err_valid}), 64'd0);
    send_instr(32'hFFFF_FFFF, 32'h0000_0000, 3'b101, 4'hF, 8);
    idle(3);

    // Too few DATA frames, then a legal AND sequence.
    send_instr(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 4'h0, 3);
    send_instr(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 4'h0, 8);
    // Illegal opcode with matching CRC, CMD with no DATA, too many DATA frames.
    send_instr(32'hCAFE_0001, 32'hBEEF_0002, 3'b111, 4'h0, 8);
    send_instr(32'h0, 32'h0, 3'b001, 4'h0, 0);
    send_instr(32'h1, 32'h2, 3'b001, 4'h0, 10);
    // Bad stop bit on a DATA frame, then recovery.
    send_frame(1'b0, 8'h5A, 1'b1);
    send_frame(1'b0, 8'hA5, 1'b0);
    idle(2);
    send_instr(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b001, 4'h0, 8);

    // Reset at bit 5 of the 4th DATA frame.
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'h77, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sin = (i == 0) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_val("midframe_reset", {instr_valid, err_valid, err_flags, op_out, A_out[15:0], B_out[15:0]}, 64'd0);
    data_q.delete();
    mdl_a  = 32'd0;
    mdl_b  = 32'd0;
    mdl_op = 3'd0;
    sin = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send_instr(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b000, 4'h0, 8);

    // Back-to-back legal OR then ADD with no idle bits between frames.
    send_instr($urandom, $urandom, 3'b001, 4'h0, 8);
    send_instr($urandom, $urandom, 3'b100, 4'h0, 8);
    idle(2);

    // Randomized stream.
    for (int n = 0; n < 30; n++) begin
      rop = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'({$urandom_range(0, 1), 1'b0, $urandom_range(0, 1)});
      send_instr($urandom, $urandom, rop,
                 ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 10)) : 8);
      if ($urandom_range(0, 9) == 0) send_frame(1'b0, 8'($urandom), 1'b0);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check_val("instr_valid_cycles", 64'(iv_cycles), 64'(exp_iv_cycles));
    check_val("err_valid_cycles", 64'(ev_cycles), 64'(exp_ev_cycles));
    check_val("both_valid_cycles", 64'(both_cycles), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
